// File: rtl/alu_regfile_core.sv
// alu_regfile_core: 32x8 regfile (async reads RS->RS_data, RT->RT_data; sync write rw/RD/RD_data; R0 = 0; sync active-high rst) feeding a combinational ALU (op -> alu_out, zero, ovf); define ALU_EXT_OPS_EN for XOR/NOR/SLTU on ops 5-7
module alu_regfile_core #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rw,
  input  logic [ADDR_W-1:0] RS,
  input  logic [ADDR_W-1:0] RT,
  input  logic [ADDR_W-1:0] RD,
  input  logic [DATA_W-1:0] RD_data,
  output logic [DATA_W-1:0] RS_data,
  output logic [DATA_W-1:0] RT_data,
  input  logic [3:0]        op,
  output logic [DATA_W-1:0] alu_out,
  output logic              zero,
  output logic              ovf
);
  localparam int M = DATA_W - 1;
  logic [DATA_W-1:0] regs [2**ADDR_W];
  logic [DATA_W-1:0] sum, dif, ext;
  logic lt;
  always_ff @(posedge clk)
    if (rst) regs <= '{default: '0};
    else if (rw && RD != '0) regs[RD] <= RD_data;
  assign RS_data = RS == '0 ? '0 : regs[RS];
  assign RT_data = RT == '0 ? '0 : regs[RT];
  always_comb begin
    sum = RS_data + RT_data;
    dif = RS_data - RT_data;
    lt = $signed(RS_data) < $signed(RT_data);
`ifdef ALU_EXT_OPS_EN
    ext = op == 4'd5 ? RS_data ^ RT_data :
          op == 4'd6 ? ~(RS_data | RT_data) :
          op == 4'd7 ? DATA_W'(RS_data < RT_data) : '0;
`else
    ext = '0;
`endif
    alu_out = op == 4'd0 ? sum :
              op == 4'd1 ? dif :
              op == 4'd2 ? RS_data & RT_data :
              op == 4'd3 ? RS_data | RT_data :
              op == 4'd4 ? DATA_W'(lt) : ext;
    ovf = op == 4'd0 ? (RS_data[M] == RT_data[M]) && (sum[M] != RS_data[M]) :
          op == 4'd1 ? (RS_data[M] != RT_data[M]) && (dif[M] != RS_data[M]) : 1'b0;
  end
  assign zero = alu_out == '0;
endmodule

// File: tb/tb_alu_regfile_core.sv
// tb_alu_regfile_core: directed-vector and exhaustive self-checking bench for alu_regfile_core
module tb_alu_regfile_core;
  logic clk = 1'b0, rst = 1'b1, rw = 1'b0;
  logic [4:0] RS = '0, RT = '0, RD = '0;
  logic [7:0] RD_data = '0;
  logic [7:0] RS_data, RT_data, alu_out;
  logic [3:0] op = '0;
  logic zero, ovf;
  int n_vec = 0, n_bad = 0;
  typedef struct {
    logic [3:0] op;
    logic [7:0] a, b, y;
    logic z, v;
  } vec_t;
  vec_t tv[18];
  always #5 clk = ~clk;
  alu_regfile_core dut (
    .clk(clk), .rst(rst), .rw(rw), .RS(RS), .RT(RT), .RD(RD), .RD_data(RD_data),
    .RS_data(RS_data), .RT_data(RT_data), .op(op), .alu_out(alu_out), .zero(zero), .ovf(ovf)
  );
  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    @(negedge clk);
    rw = 1'b1; RD = a; RD_data = d;
    @(posedge clk);
    #1 rw = 1'b0;
  endtask
  function automatic int sx(input logic [7:0] x);
    return x > 8'd127 ? int'(x) - 256 : int'(x);
  endfunction
  function automatic int model_y(input int o, input logic [7:0] a, input logic [7:0] b);
    int r;
    case (o)
      0: r = (int'(a) + int'(b)) % 256;
      1: r = (int'(a) - int'(b) + 256) % 256;
      2: r = int'(a & b);
      3: r = int'(a | b);
      4: r = sx(a) < sx(b) ? 1 : 0;
      default: r = 0;
    endcase
    return r;
  endfunction
  function automatic int model_v(input int o, input logic [7:0] a, input logic [7:0] b);
    int s;
    s = o == 0 ? sx(a) + sx(b) : o == 1 ? sx(a) - sx(b) : 0;
    return (s > 127 || s < -128) ? 1 : 0;
  endfunction
  initial begin
    tv[0]  = '{4'd0, 8'd255, 8'd1,   8'd0,   1'b1, 1'b0};
    tv[1]  = '{4'd0, 8'd127, 8'd1,   8'd128, 1'b0, 1'b1};
    tv[2]  = '{4'd0, 8'd128, 8'd128, 8'd0,   1'b1, 1'b1};
    tv[3]  = '{4'd1, 8'd0,   8'd1,   8'd255, 1'b0, 1'b0};
    tv[4]  = '{4'd1, 8'd0,   8'd0,   8'd0,   1'b1, 1'b0};
    tv[5]  = '{4'd1, 8'd128, 8'd1,   8'd127, 1'b0, 1'b1};
    tv[6]  = '{4'd1, 8'd127, 8'd255, 8'd128, 1'b0, 1'b1};
    tv[7]  = '{4'd2, 8'hF0,  8'h3C,  8'h30,  1'b0, 1'b0};
    tv[8]  = '{4'd3, 8'hF0,  8'h0F,  8'hFF,  1'b0, 1'b0};
    tv[9]  = '{4'd4, 8'hFF,  8'd1,   8'd1,   1'b0, 1'b0};
    tv[10] = '{4'd4, 8'd1,   8'hFF,  8'd0,   1'b1, 1'b0};
    tv[11] = '{4'd4, 8'd5,   8'd5,   8'd0,   1'b1, 1'b0};
    tv[12] = '{4'd8, 8'd3,   8'd5,   8'd0,   1'b1, 1'b0};
    tv[13] = '{4'd15, 8'hFF, 8'hFF,  8'd0,   1'b1, 1'b0};
`ifdef ALU_EXT_OPS_EN
    tv[14] = '{4'd5, 8'hF0,  8'hFF,  8'h0F,  1'b0, 1'b0};
    tv[15] = '{4'd6, 8'hF0,  8'h0F,  8'h00,  1'b1, 1'b0};
    tv[16] = '{4'd7, 8'd1,   8'hFF,  8'd1,   1'b0, 1'b0};
    tv[17] = '{4'd7, 8'hFF,  8'd1,   8'd0,   1'b1, 1'b0};
`else
    tv[14] = '{4'd5, 8'hF0,  8'hFF,  8'd0,   1'b1, 1'b0};
    tv[15] = '{4'd6, 8'hF0,  8'h0F,  8'd0,   1'b1, 1'b0};
    tv[16] = '{4'd7, 8'd1,   8'hFF,  8'd0,   1'b1, 1'b0};
    tv[17] = '{4'd7, 8'hFF,  8'd1,   8'd0,   1'b1, 1'b0};
`endif
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      RS = 5'(i); RT = 5'(31 - i);
      #1 chk("reset_rs", RS_data, 0);
      chk("reset_rt", RT_data, 0);
    end
    RS = 5'd7; RT = 5'd9;
    for (int o = 0; o < 5; o++) begin
      op = 4'(o);
      #1 chk("reset_alu", alu_out, 0);
      chk("reset_zero", zero, 1);
      chk("reset_ovf", ovf, 0);
    end
    for (int i = 0; i < 18; i++) begin
      wr(5'd1, tv[i].a);
      wr(5'd2, tv[i].b);
      RS = 5'd1; RT = 5'd2; op = tv[i].op;
      #1 chk($sformatf("vec%0d_y", i), alu_out, tv[i].y);
      chk($sformatf("vec%0d_zero", i), zero, tv[i].z);
      chk($sformatf("vec%0d_ovf", i), ovf, tv[i].v);
    end
    for (int r = 1; r < 8; r++)
      for (int v = 0; v < 256; v++) begin
        wr(5'(r), 8'(v));
        RS = 5'(r); RT = 5'(r);
        #1 chk("sweep_rs", RS_data, v);
        chk("sweep_rt", RT_data, v);
      end
    wr(5'd0, 8'hAA);
    RS = 5'd0; RT = 5'd0;
    #1 chk("r0_rs", RS_data, 0);
    chk("r0_rt", RT_data, 0);
    wr(5'd3, 8'd5);
    @(negedge clk);
    rw = 1'b1; RD = 5'd3; RS = 5'd3; RD_data = 8'd9;
    #1 chk("hazard_before", RS_data, 5);
    @(posedge clk);
    #1 rw = 1'b0;
    chk("hazard_after", RS_data, 9);
    wr(5'd2, 8'd33);
    @(negedge clk);
    rst = 1'b1; rw = 1'b1; RD = 5'd2; RD_data = 8'd7;
    @(posedge clk);
    #1 rst = 1'b0; rw = 1'b0; RS = 5'd2; RT = 5'd3;
    #1 chk("rst_rw_r2", RS_data, 0);
    chk("rst_rw_r3", RT_data, 0);
    for (int r = 1; r < 32; r++) wr(5'(r), 8'($urandom_range(1, 255)));
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      RS = 5'(i); RT = 5'(i);
      #1 chk("rerst_rs", RS_data, 0);
      chk("rerst_rt", RT_data, 0);
    end
    for (int c = 0; c < 16; c++) begin
      for (int j = 0; j < 16; j++) wr(5'(16 + j), 8'(c * 16 + j));
      for (int a = 0; a < 256; a++) begin
        wr(5'd1, 8'(a));
        RS = 5'd1;
        for (int j = 0; j < 16; j++) begin
          RT = 5'(16 + j);
          for (int o = 0; o < 5; o++) begin
            op = 4'(o);
            #1 chk($sformatf("alu op%0d a=%0h b=%0h", o, a, c * 16 + j), alu_out,
                   model_y(o, 8'(a), 8'(c * 16 + j)));
            chk($sformatf("ovf op%0d a=%0h b=%0h", o, a, c * 16 + j), ovf,
                model_v(o, 8'(a), 8'(c * 16 + j)));
            chk("zero", zero, model_y(o, 8'(a), 8'(c * 16 + j)) == 0 ? 1 : 0);
          end
        end
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
